// File: rtl/mux_tree_pipe_config.sv
// Configurable 2^K:1 mux tree with an optional tapped partial-tree output.
// ConfigBits[3:2] pick the timing mode: combinational, a single output
// register, or fully pipelined with one register per tree level.
// ConfigBits[1:0] pick the tap level. A valid chain tracks EN through the
// active mode's latency and is flushed whenever the configuration changes.
module mux_tree_pipe_config #(
  parameter int SEL_BITS     = 3,
  parameter int NoConfigBits = 4
) (
  input  logic                        UserCLK,
  input  logic                        SR,
  input  logic                        EN,
  input  logic [(1<<SEL_BITS)-1:0]    I,
  input  logic [SEL_BITS-1:0]         S,
  input  logic [NoConfigBits-1:0]     ConfigBits,
  output logic                        M_FULL,
  output logic                        M_TAP,
  output logic                        Q_VALID
);

  localparam int K = SEL_BITS;
  localparam int N = 1 << SEL_BITS;

  logic [NoConfigBits-1:0] cfg_q;
  logic                    chg_s;
  logic                    pipe_s;
  logic                    sreg_s;
  logic [2:0]              tap_lvl_s;
  logic [K-1:0]            tap_mask_s;
  logic                    comb_full_s;
  logic                    comb_tap_s;
  logic                    sfull_q;
  logic                    stap_q;

  // Stage j register holds level-j nodes; src arrays present the input of each stage.
  logic [N-1:0] src_s     [0:K-1];
  logic [K-1:0] src_sel_s [0:K-1];
  logic         src_tap_s [0:K-1];
  logic [N-1:0] lvl_d     [1:K];
  logic [N-1:0] lvl_q     [1:K];
  logic [K-1:0] sel_d     [1:K-1];
  logic [K-1:0] sel_q     [1:K-1];
  logic         tap_d     [1:K];
  logic         tap_q     [1:K];
  logic [K:1]   vld_d;
  logic [K:1]   vld_q;

  // Decode mode, clamped tap level and config-change detect; combinational tree results.
  always_comb begin
    chg_s  = (ConfigBits != cfg_q);
    pipe_s = ConfigBits[3] & ConfigBits[2];
    sreg_s = ConfigBits[3] & ~ConfigBits[2];
    tap_lvl_s = {1'b0, ConfigBits[1:0]} + 3'd1;
    if (tap_lvl_s > 3'(K)) begin
      tap_lvl_s = 3'(K);
    end else begin
      tap_lvl_s = tap_lvl_s;
    end
    tap_mask_s = '0;
    for (int b = 0; b < K; b++) begin
      tap_mask_s[b] = (b < int'(tap_lvl_s));
    end
    comb_full_s = I[S];
    comb_tap_s  = I[S & tap_mask_s];
  end

  // Per-level mux network for the pipelined mode, with selects and tap travelling alongside.
  always_comb begin
    src_s[0]     = I;
    src_sel_s[0] = S;
    src_tap_s[0] = 1'b0;
    for (int j = 1; j < K; j++) begin
      src_s[j]     = lvl_q[j];
      src_sel_s[j] = sel_q[j];
      src_tap_s[j] = tap_q[j];
    end
    for (int j = 1; j <= K; j++) begin
      lvl_d[j] = '0;
      for (int n = 0; n < N / 2; n++) begin
        if (n < (N >> j)) begin
          lvl_d[j][n] = src_sel_s[j-1][j-1] ? src_s[j-1][2*n+1] : src_s[j-1][2*n];
        end else begin
          lvl_d[j][n] = 1'b0;
        end
      end
      if (j == int'(tap_lvl_s)) begin
        tap_d[j] = lvl_d[j][0];
      end else if (j > int'(tap_lvl_s)) begin
        tap_d[j] = src_tap_s[j-1];
      end else begin
        tap_d[j] = 1'b0;
      end
    end
    for (int j = 1; j < K; j++) begin
      sel_d[j] = src_sel_s[j-1];
    end
    vld_d[1] = EN;
    for (int j = 2; j <= K; j++) begin
      vld_d[j] = vld_q[j-1];
    end
  end

  // State update: reset clears everything, a config change flushes only the valid chain.
  always_ff @(posedge UserCLK) begin
    cfg_q <= ConfigBits;
    if (SR) begin
      vld_q   <= '0;
      sfull_q <= 1'b0;
      stap_q  <= 1'b0;
      for (int j = 1; j <= K; j++) begin
        lvl_q[j] <= '0;
        tap_q[j] <= 1'b0;
      end
      for (int j = 1; j < K; j++) begin
        sel_q[j] <= '0;
      end
    end else begin
      sfull_q <= comb_full_s;
      stap_q  <= comb_tap_s;
      for (int j = 1; j <= K; j++) begin
        lvl_q[j] <= lvl_d[j];
        tap_q[j] <= tap_d[j];
      end
      for (int j = 1; j < K; j++) begin
        sel_q[j] <= sel_d[j];
      end
      if (chg_s) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
    end
  end

  // Output selection by mode; a pending config change always masks the valid flag.
  always_comb begin
    if (pipe_s) begin
      M_FULL  = lvl_q[K][0];
      M_TAP   = tap_q[K];
      Q_VALID = vld_q[K] & ~chg_s;
    end else if (sreg_s) begin
      M_FULL  = sfull_q;
      M_TAP   = stap_q;
      Q_VALID = vld_q[1] & ~chg_s;
    end else begin
      M_FULL  = comb_full_s;
      M_TAP   = comb_tap_s;
      Q_VALID = EN & ~chg_s;
    end
  end

endmodule

// File: tb/tb_mux_tree_pipe_config.sv
// Self-checking bench for mux_tree_pipe_config (K=3 main instance, K=2 clamp instance).
// Expected values come from a per-cycle history of inputs and a rule-based model.
module tb_mux_tree_pipe_config;

  localparam int K = 3;

  logic       UserCLK = 1'b0;
  logic       SR = 1'b1;
  logic       EN = 1'b0;
  logic [7:0] I = 8'h00;
  logic [2:0] S = 3'd0;
  logic [3:0] ConfigBits = 4'b1101;
  logic       M_FULL, M_TAP, Q_VALID;
  logic       M_FULL2, M_TAP2, Q_VALID2;

  int checks = 0;
  int errors = 0;
  int cyc = -1;

  logic [7:0] i_h   [0:1023];
  logic [2:0] s_h   [0:1023];
  logic [3:0] cfg_h [0:1023];
  bit         en_h  [0:1023];
  bit         sr_h  [0:1023];

  mux_tree_pipe_config #(.SEL_BITS(3), .NoConfigBits(4)) dut (
    .UserCLK(UserCLK), .SR(SR), .EN(EN), .I(I), .S(S), .ConfigBits(ConfigBits),
    .M_FULL(M_FULL), .M_TAP(M_TAP), .Q_VALID(Q_VALID)
  );

  mux_tree_pipe_config #(.SEL_BITS(2), .NoConfigBits(4)) dut2 (
    .UserCLK(UserCLK), .SR(SR), .EN(EN), .I(I[3:0]), .S(S[1:0]), .ConfigBits(ConfigBits),
    .M_FULL(M_FULL2), .M_TAP(M_TAP2), .Q_VALID(Q_VALID2)
  );

  always #5 UserCLK = ~UserCLK;

  // Latency in cycles for the mode configured in cycle t.
  function automatic int lat_of(int t, int k);
    logic [3:0] c;
    c = cfg_h[t];
    if (!c[3]) return 0;
    if (!c[2]) return 1;
    return k;
  endfunction

  // A sample is visible if it was entered with EN=1 and no config change or reset edge hit it.
  function automatic bit exp_valid(int t, int k);
    int s;
    s = t - lat_of(t, k);
    if (s < 0) return 1'b0;
    if (!en_h[s]) return 1'b0;
    for (int u = s; u <= t; u++) begin
      if (u >= 1 && cfg_h[u] != cfg_h[u-1]) return 1'b0;
    end
    for (int u = s; u < t; u++) begin
      if (sr_h[u]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_full(int t, int k);
    int s, idx;
    s   = t - lat_of(t, k);
    idx = int'(s_h[s]) % (1 << k);
    return i_h[s][idx];
  endfunction

  function automatic logic exp_tap(int t, int k);
    int s, idx, l;
    logic [3:0] c;
    c = cfg_h[t];
    s = t - lat_of(t, k);
    l = int'(c[1:0]) + 1;
    if (l > k) l = k;
    idx = int'(s_h[s]) % (1 << l);
    return i_h[s][idx];
  endfunction

  // Apply one cycle of inputs after the edge, log them, then settle to the sampling point.
  task automatic drive(input bit sr, input bit en, input logic [3:0] cfg,
                       input logic [7:0] iv, input logic [2:0] sv);
    @(posedge UserCLK);
    #1;
    SR = sr; EN = en; ConfigBits = cfg; I = iv; S = sv;
    cyc++;
    i_h[cyc] = iv; s_h[cyc] = sv; cfg_h[cyc] = cfg; en_h[cyc] = en; sr_h[cyc] = sr;
    @(negedge UserCLK);
  endtask

  task automatic test_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b1, 4'b1101, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", cyc, Q_VALID); end
      checks++;
      if (M_FULL !== 1'b0) begin errors++; $display("FAIL reset_full cyc=%0d got=%b exp=0", cyc, M_FULL); end
      checks++;
      if (M_TAP !== 1'b0) begin errors++; $display("FAIL reset_tap cyc=%0d got=%b exp=0", cyc, M_TAP); end
    end
  endtask

  task automatic test_comb();
    drive(1'b0, 1'b0, 4'b0001, 8'h00, 3'd0);
    checks++;
    if (Q_VALID !== 1'b0) begin errors++; $display("FAIL comb_chg_valid got=%b exp=0", Q_VALID); end
    drive(1'b0, 1'b1, 4'b0001, 8'hA6, 3'b110);
    checks++;
    if (Q_VALID !== 1'b1) begin errors++; $display("FAIL comb_vec_valid got=%b exp=1", Q_VALID); end
    checks++;
    if (M_FULL !== 1'b0) begin errors++; $display("FAIL comb_vec_full got=%b exp=0", M_FULL); end
    checks++;
    if (M_TAP !== 1'b1) begin errors++; $display("FAIL comb_vec_tap got=%b exp=1", M_TAP); end
    for (int n = 0; n < 20; n++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== exp_valid(cyc, K)) begin errors++; $display("FAIL comb_valid cyc=%0d got=%b exp=%b", cyc, Q_VALID, exp_valid(cyc, K)); end
      if (exp_valid(cyc, K)) begin
        checks++;
        if (M_FULL !== exp_full(cyc, K)) begin errors++; $display("FAIL comb_full cyc=%0d got=%b exp=%b", cyc, M_FULL, exp_full(cyc, K)); end
        checks++;
        if (M_TAP !== exp_tap(cyc, K)) begin errors++; $display("FAIL comb_tap cyc=%0d got=%b exp=%b", cyc, M_TAP, exp_tap(cyc, K)); end
      end
    end
  endtask

  task automatic test_sreg();
    bit pat [0:2];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
    drive(1'b0, 1'b0, 4'b1000, 8'($urandom), 3'($urandom));
    for (int n = 0; n < 30; n++) begin
      drive(1'b0, (n < 3) ? pat[n] : 1'($urandom_range(0, 1)), 4'b1000, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== exp_valid(cyc, K)) begin errors++; $display("FAIL sreg_valid cyc=%0d got=%b exp=%b", cyc, Q_VALID, exp_valid(cyc, K)); end
      if (exp_valid(cyc, K)) begin
        checks++;
        if (M_FULL !== exp_full(cyc, K)) begin errors++; $display("FAIL sreg_full cyc=%0d got=%b exp=%b", cyc, M_FULL, exp_full(cyc, K)); end
        checks++;
        if (M_TAP !== exp_tap(cyc, K)) begin errors++; $display("FAIL sreg_tap cyc=%0d got=%b exp=%b", cyc, M_TAP, exp_tap(cyc, K)); end
      end
    end
  endtask

  task automatic test_pipe();
    logic [2:0] sv [0:2];
    logic       ef [0:2];
    sv[0] = 3'd6; sv[1] = 3'd5; sv[2] = 3'd1;
    ef[0] = 1'b0; ef[1] = 1'b1; ef[2] = 1'b1;
    drive(1'b0, 1'b0, 4'b1101, 8'($urandom), 3'($urandom));
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 4'b1101, 8'hA6, sv[n]);
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b0, 4'b1101, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== 1'b1) begin errors++; $display("FAIL pipe_vec_valid n=%0d got=%b exp=1", n, Q_VALID); end
      checks++;
      if (M_FULL !== ef[n]) begin errors++; $display("FAIL pipe_vec_full n=%0d got=%b exp=%b", n, M_FULL, ef[n]); end
      checks++;
      if (M_TAP !== 1'b1) begin errors++; $display("FAIL pipe_vec_tap n=%0d got=%b exp=1", n, M_TAP); end
    end
    for (int n = 0; n < 30; n++) begin
      drive(1'b0, 1'($urandom_range(0, 3) != 0), 4'b1101, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== exp_valid(cyc, K)) begin errors++; $display("FAIL pipe_valid cyc=%0d got=%b exp=%b", cyc, Q_VALID, exp_valid(cyc, K)); end
      if (exp_valid(cyc, K)) begin
        checks++;
        if (M_FULL !== exp_full(cyc, K)) begin errors++; $display("FAIL pipe_full cyc=%0d got=%b exp=%b", cyc, M_FULL, exp_full(cyc, K)); end
        checks++;
        if (M_TAP !== exp_tap(cyc, K)) begin errors++; $display("FAIL pipe_tap cyc=%0d got=%b exp=%b", cyc, M_TAP, exp_tap(cyc, K)); end
      end
    end
  endtask

  task automatic test_cfg_change();
    logic [3:0] cfg;
    for (int n = 0; n < 36; n++) begin
      if (n < 10) cfg = 4'b1101;
      else if (n < 20) cfg = 4'b1111;
      else if (n < 24) cfg = 4'b1100;
      else if (n < 31) cfg = 4'b1001;
      else cfg = 4'b0010;
      drive(1'b0, (n >= 10 && n < 14) ? 1'b1 : 1'($urandom_range(0, 3) != 0), cfg, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== exp_valid(cyc, K)) begin errors++; $display("FAIL chg_valid cyc=%0d got=%b exp=%b", cyc, Q_VALID, exp_valid(cyc, K)); end
      if (exp_valid(cyc, K)) begin
        checks++;
        if (M_FULL !== exp_full(cyc, K)) begin errors++; $display("FAIL chg_full cyc=%0d got=%b exp=%b", cyc, M_FULL, exp_full(cyc, K)); end
        checks++;
        if (M_TAP !== exp_tap(cyc, K)) begin errors++; $display("FAIL chg_tap cyc=%0d got=%b exp=%b", cyc, M_TAP, exp_tap(cyc, K)); end
      end
    end
  endtask

  task automatic test_sr_flight();
    for (int n = 0; n < 22; n++) begin
      drive((n == 4 || n == 14) ? 1'b1 : 1'b0, (n == 0) ? 1'b0 : 1'($urandom_range(0, 4) != 0),
            (n < 11) ? 4'b1101 : 4'b1010, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID !== exp_valid(cyc, K)) begin errors++; $display("FAIL sr_valid cyc=%0d got=%b exp=%b", cyc, Q_VALID, exp_valid(cyc, K)); end
      if (sr_h[cyc-1]) begin
        checks++;
        if (M_FULL !== 1'b0) begin errors++; $display("FAIL sr_zero_full cyc=%0d got=%b exp=0", cyc, M_FULL); end
        checks++;
        if (M_TAP !== 1'b0) begin errors++; $display("FAIL sr_zero_tap cyc=%0d got=%b exp=0", cyc, M_TAP); end
      end else if (exp_valid(cyc, K)) begin
        checks++;
        if (M_FULL !== exp_full(cyc, K)) begin errors++; $display("FAIL sr_full cyc=%0d got=%b exp=%b", cyc, M_FULL, exp_full(cyc, K)); end
        checks++;
        if (M_TAP !== exp_tap(cyc, K)) begin errors++; $display("FAIL sr_tap cyc=%0d got=%b exp=%b", cyc, M_TAP, exp_tap(cyc, K)); end
      end else begin
        checks++;
        if (Q_VALID !== 1'b0) begin errors++; $display("FAIL sr_bubble cyc=%0d got=%b exp=0", cyc, Q_VALID); end
      end
    end
  endtask

  task automatic test_clamp_k2();
    for (int n = 0; n < 22; n++) begin
      drive(1'b0, 1'($urandom_range(0, 3) != 0), (n < 14) ? 4'b1111 : 4'b0011, 8'($urandom), 3'($urandom));
      checks++;
      if (Q_VALID2 !== exp_valid(cyc, 2)) begin errors++; $display("FAIL k2_valid cyc=%0d got=%b exp=%b", cyc, Q_VALID2, exp_valid(cyc, 2)); end
      if (exp_valid(cyc, 2)) begin
        checks++;
        if (M_FULL2 !== exp_full(cyc, 2)) begin errors++; $display("FAIL k2_full cyc=%0d got=%b exp=%b", cyc, M_FULL2, exp_full(cyc, 2)); end
        checks++;
        if (M_TAP2 !== exp_full(cyc, 2)) begin errors++; $display("FAIL k2_tap_clamp cyc=%0d got=%b exp=%b", cyc, M_TAP2, exp_full(cyc, 2)); end
      end
      if (exp_valid(cyc, K)) begin
        checks++;
        if (M_TAP !== exp_full(cyc, K)) begin errors++; $display("FAIL k3_tap_clamp cyc=%0d got=%b exp=%b", cyc, M_TAP, exp_full(cyc, K)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_sreg();
    test_pipe();
    test_cfg_change();
    test_sr_flight();
    test_clamp_k2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
